// File: rtl/mul_err_sweeper_if.sv
// Operand/product bus between the error sweeper and a multiplier under test,
// plus the sweep handshake and the accumulated error metrics.
interface mul_err_sweeper_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ED_W  = 40
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     mul_in1;
  logic [WIDTH-1:0]     mul_in2;
  logic [2*WIDTH-2:0]   mul_out;
  logic                 mul_ovf;
  logic [2*WIDTH:0]     err_count;
  logic [2*WIDTH-1:0]   max_ed;
  logic [ED_W-1:0]      sum_ed;
  logic                 first_err_valid;
  logic [WIDTH-1:0]     first_err_a;
  logic [WIDTH-1:0]     first_err_b;

  modport master (
    input  start, mul_out, mul_ovf,
    output busy, done, mul_in1, mul_in2, err_count, max_ed, sum_ed,
           first_err_valid, first_err_a, first_err_b
  );

  modport slave (
    output start, mul_out, mul_ovf,
    input  busy, done, mul_in1, mul_in2, err_count, max_ed, sum_ed,
           first_err_valid, first_err_a, first_err_b
  );
endinterface

// File: rtl/mul_err_sweeper.sv
// Drives every operand pair into a multiplier under test and accumulates error
// metrics (count, max/sum of error distance, first failing pair) against A*B.
module mul_err_sweeper #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 0,
  parameter int unsigned ED_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  mul_err_sweeper_if.master io_bus
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned DW = $clog2(LAT + 3);
  // Drain covers the alignment pipe, the sample stage, the compare stage and accumulate.
  localparam logic [DW-1:0] DrainLast = DW'(LAT + 2);

  typedef enum logic [1:0] {StIdle, StDrive, StDrain, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [PW-1:0] r_cnt, w_cnt_d;
  logic [DW-1:0] r_dcnt, w_dcnt_d;
  logic          w_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_dcnt  <= w_dcnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_dcnt_d  = '0;
    w_clr     = 1'b0;
    case (r_state)
      StIdle: begin
        if (io_bus.start) begin
          w_state_d = StDrive;
          w_cnt_d   = '0;
          w_clr     = 1'b1;
        end
      end
      StDrive: begin
        // The counter wraps to 0 on the last pair, which also zeroes the operands.
        w_cnt_d = r_cnt + PW'(1);
        if (&r_cnt) w_state_d = StDrain;
      end
      StDrain: begin
        w_dcnt_d = r_dcnt + DW'(1);
        if (r_dcnt == DrainLast) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign io_bus.busy    = (r_state == StDrive) || (r_state == StDrain);
  assign io_bus.done    = (r_state == StDone);
  assign io_bus.mul_in1 = r_cnt[WIDTH-1:0];
  assign io_bus.mul_in2 = r_cnt[PW-1:WIDTH];

  logic          w_drv_v;
  logic          w_al_v;
  logic [PW-1:0] w_al_op;

  assign w_drv_v = (r_state == StDrive);

  if (LAT == 0) begin : g_direct
    assign w_al_v  = w_drv_v;
    assign w_al_op = r_cnt;
  end else begin : g_align
    logic [LAT-1:0] r_pv;
    logic [PW-1:0]  r_pop [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_pv <= '0;
        for (int k = 0; k < LAT; k++) r_pop[k] <= '0;
      end else begin
        r_pv[0]  <= w_drv_v;
        r_pop[0] <= r_cnt;
        for (int k = 1; k < LAT; k++) begin
          r_pv[k]  <= r_pv[k-1];
          r_pop[k] <= r_pop[k-1];
        end
      end
    end

    assign w_al_v  = r_pv[LAT-1];
    assign w_al_op = r_pop[LAT-1];
  end

  logic          r_s_v;
  logic [PW-1:0] r_s_op;
  logic [PW-1:0] r_s_p;
  logic          r_c_v;
  logic          r_c_mis;
  logic [PW-1:0] r_c_ed;
  logic [PW-1:0] r_c_op;
  logic [PW-1:0] w_pex;
  logic [PW-1:0] w_ed;
  logic          w_mis;

  assign w_pex = PW'(r_s_op[WIDTH-1:0]) * PW'(r_s_op[PW-1:WIDTH]);
  assign w_mis = (w_pex != r_s_p);
  assign w_ed  = (w_pex >= r_s_p) ? (w_pex - r_s_p) : (r_s_p - w_pex);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_v   <= 1'b0;
      r_s_op  <= '0;
      r_s_p   <= '0;
      r_c_v   <= 1'b0;
      r_c_mis <= 1'b0;
      r_c_ed  <= '0;
      r_c_op  <= '0;
    end else begin
      r_s_v   <= w_al_v;
      r_s_op  <= w_al_op;
      r_s_p   <= {io_bus.mul_ovf, io_bus.mul_out};
      r_c_v   <= r_s_v;
      r_c_mis <= w_mis;
      r_c_ed  <= w_ed;
      r_c_op  <= r_s_op;
    end
  end

  logic [PW:0]      r_err;
  logic [PW-1:0]    r_max;
  logic [ED_W-1:0]  r_sum;
  logic             r_fv;
  logic [WIDTH-1:0] r_fa;
  logic [WIDTH-1:0] r_fb;
  logic [ED_W:0]    w_sum_wide;

  assign w_sum_wide = {1'b0, r_sum} + (ED_W + 1)'(r_c_ed);

  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_err <= '0;
      r_max <= '0;
      r_sum <= '0;
      r_fv  <= 1'b0;
      r_fa  <= '0;
      r_fb  <= '0;
    end else if (r_c_v && r_c_mis) begin
      r_err <= r_err + (PW + 1)'(1);
      r_sum <= w_sum_wide[ED_W] ? '1 : w_sum_wide[ED_W-1:0];
      if (r_c_ed > r_max) r_max <= r_c_ed;
      if (!r_fv) begin
        r_fv <= 1'b1;
        r_fa <= r_c_op[WIDTH-1:0];
        r_fb <= r_c_op[PW-1:WIDTH];
      end
    end
  end

  assign io_bus.err_count       = r_err;
  assign io_bus.max_ed          = r_max;
  assign io_bus.sum_ed          = r_sum;
  assign io_bus.first_err_valid = r_fv;
  assign io_bus.first_err_a     = r_fa;
  assign io_bus.first_err_b     = r_fb;
endmodule

// File: tb/tb_mul_err_sweeper.sv
// Bench for mul_err_sweeper: a table-driven 2-stage multiplier stub, a plain
// arithmetic metric model feeding a scoreboard, and a done-triggered monitor.
module tb_mul_err_sweeper;
  localparam int unsigned W    = 4;
  localparam int unsigned LAT  = 2;
  localparam int unsigned ED_W = 10;
  localparam int unsigned PW   = 2 * W;
  localparam int unsigned NP   = 1 << PW;
  localparam int unsigned NA   = 1 << W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mul_err_sweeper_if #(.WIDTH(W), .ED_W(ED_W)) bus ();

  mul_err_sweeper #(.WIDTH(W), .LAT(LAT), .ED_W(ED_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  // Multiplier stub: product looked up from a table, then LAT=2 register stages.
  logic [PW-1:0] tab [NP];
  logic [PW-1:0] st1, st2;
  always @(posedge clk) begin
    st1 <= tab[{bus.mul_in2, bus.mul_in1}];
    st2 <= st1;
  end
  assign {bus.mul_ovf, bus.mul_out} = st2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] err;
    logic [63:0] maxed;
    logic [63:0] sum;
    logic [63:0] fv;
    logic [63:0] fa;
    logic [63:0] fb;
    logic [63:0] done_cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   n_exp  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, want);
    end
  endtask

  function automatic exp_t model();
    exp_t   e;
    longint err = 0, mx = 0, sum = 0, ex, ap, ed;
    longint lim = (longint'(1) << ED_W) - 1;
    bit     fv = 1'b0;
    int     fa = 0, fb = 0;
    logic [PW-1:0] idx;
    for (int b = 0; b < NA; b++) begin
      for (int a = 0; a < NA; a++) begin
        idx = PW'(b * NA + a);
        ex  = longint'(a * b);
        ap  = longint'(tab[idx]);
        if (ex != ap) begin
          ed = (ex > ap) ? ex - ap : ap - ex;
          err++;
          sum += ed;
          if (ed > mx) mx = ed;
          if (!fv) begin
            fv = 1'b1;
            fa = a;
            fb = b;
          end
        end
      end
    end
    if (sum > lim) sum = lim;
    e.err   = 64'(err);
    e.maxed = 64'(mx);
    e.sum   = 64'(sum);
    e.fv    = 64'(fv);
    e.fa    = 64'(fa);
    e.fb    = 64'(fb);
    e.done_cyc = '0;
    return e;
  endfunction

  // mode 0 exact, 1 bit0 cleared, 2 zero only at max*max, 3 all zero, else random.
  task automatic fill(input int mode, input int dens);
    logic [PW-1:0] ex, v, idx;
    for (int b = 0; b < NA; b++) begin
      for (int a = 0; a < NA; a++) begin
        ex  = PW'(a * b);
        idx = PW'(b * NA + a);
        case (mode)
          0: v = ex;
          1: v = ex & ~PW'(1);
          2: v = (a == NA - 1 && b == NA - 1) ? '0 : ex;
          3: v = '0;
          default: v = ($urandom_range(0, 99) < dens) ? PW'($urandom) : ex;
        endcase
        tab[idx] = v;
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done at cycle %0d, want no done", cyc);
      end else begin
        e = sb.pop_front();
        chk("err_count", 64'(bus.err_count), e.err);
        chk("max_ed", 64'(bus.max_ed), e.maxed);
        chk("sum_ed", 64'(bus.sum_ed), e.sum);
        chk("first_err_valid", 64'(bus.first_err_valid), e.fv);
        chk("first_err_a", 64'(bus.first_err_a), e.fa);
        chk("first_err_b", 64'(bus.first_err_b), e.fb);
        chk("done_latency", 64'(cyc), e.done_cyc);
        chk("busy_in_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_in1"}, 64'(bus.mul_in1), 64'd0);
    chk({tag, "_in2"}, 64'(bus.mul_in2), 64'd0);
    chk({tag, "_err_count"}, 64'(bus.err_count), 64'd0);
    chk({tag, "_max_ed"}, 64'(bus.max_ed), 64'd0);
    chk({tag, "_sum_ed"}, 64'(bus.sum_ed), 64'd0);
    chk({tag, "_fv"}, 64'(bus.first_err_valid), 64'd0);
    chk({tag, "_fa"}, 64'(bus.first_err_a), 64'd0);
    chk({tag, "_fb"}, 64'(bus.first_err_b), 64'd0);
  endtask

  task automatic run_sweep(input int mode, input int dens, input bit pulse_mid,
                           input bit pulse_done);
    exp_t e;
    bit   got = 1'b0;
    fill(mode, dens);
    e = model();
    @(negedge clk);
    bus.start  = 1'b1;
    e.done_cyc = 64'(cyc + NP + LAT + 4);
    sb.push_back(e);
    n_exp++;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    for (int i = 0; i < NP + LAT + 20 && !got; i++) begin
      @(negedge clk);
      bus.start = pulse_mid && (i == 40);
      got = bus.done;
    end
    chk("done_seen", 64'(got), 64'd1);
    if (!got) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      return;
    end
    if (pulse_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_one_cycle", 64'(bus.done), 64'd0);
    chk("idle_after_done", 64'(bus.busy), 64'd0);
    if (pulse_done) begin
      repeat (3) @(negedge clk);
      chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    fill(0, 0);
    repeat (3) @(negedge clk);
    check_zero("reset");

    // start together with rst: reset must win.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    check_zero("rst_wins");

    run_sweep(0, 0, 1'b0, 1'b0);
    run_sweep(1, 0, 1'b1, 1'b0);
    run_sweep(2, 0, 1'b0, 1'b1);
    run_sweep(3, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) run_sweep(4, 3 + i * 15, i == 1, i == 2);

    // Abort a sweep that has already accumulated errors.
    fill(1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("mid_rst");
    repeat (NP + LAT + 10) @(negedge clk);
    chk("no_done_after_abort", 64'(n_done), 64'(n_exp));
    run_sweep(1, 0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("done_count", 64'(n_done), 64'(n_exp));
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
    $fatal(1);
  end
endmodule
